// File: rtl/wb_regfile.sv
// Writeback stage of the 8-bit pipeline: MEM-stage capture, 4 x 8-bit register
// file with bypassed decode read ports, load-use stall FSM and retired-write counter.
module wb_regfile #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             Wr_MEM,
    input  logic             Rm_MEM,
    input  logic [1:0]       rdmem,
    input  logic [7:0]       data_out,
    input  logic [7:0]       acOutWb,
    input  logic [1:0]       rs_a,
    input  logic [1:0]       rs_b,
    input  logic             use_a,
    input  logic             use_b,
    input  logic             Rm_EX,
    input  logic [1:0]       rd_EX,
    output logic [7:0]       regA,
    output logic [7:0]       regB,
    output logic             stall,
    output logic             wb_valid,
    output logic [1:0]       wb_rd,
    output logic [7:0]       wb_value,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t           state_r;
    logic             v_r;
    logic [1:0]       rd_r;
    logic [7:0]       val_r;
    logic [7:0]       regs_r [4];
    logic [CNT_W-1:0] retired_r;
    logic             hazard_s;

    // Stage register; the load/ALU select is resolved at capture time.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_r   <= 1'b0;
            rd_r  <= 2'd0;
            val_r <= 8'h00;
        end else begin
            v_r   <= Wr_MEM;
            rd_r  <= rdmem;
            val_r <= Rm_MEM ? data_out : acOutWb;
        end
    end

    // Commit the pending write into the register file.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (v_r) begin
            regs_r[rd_r] <= val_r;
        end
    end

    // Retired-write counter, saturating at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (v_r && (retired_r != {CNT_W{1'b1}})) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Hazard FSM: BUBBLE masks the stale Rm_EX left behind by the injected bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RUN;
        end else begin
            case (state_r)
                RUN:     state_r <= hazard_s ? BUBBLE : RUN;
                BUBBLE:  state_r <= RUN;
                default: state_r <= RUN;
            endcase
        end
    end

    // Decode read ports with same-cycle bypass from the pending write.
    always_comb begin
        if (v_r && (rd_r == rs_a)) begin
            regA = val_r;
        end else begin
            regA = regs_r[rs_a];
        end
        if (v_r && (rd_r == rs_b)) begin
            regB = val_r;
        end else begin
            regB = regs_r[rs_b];
        end
    end

    // Load-use detection against the load currently in EX.
    always_comb begin
        hazard_s = Rm_EX && ((use_a && (rd_EX == rs_a)) || (use_b && (rd_EX == rs_b)));
        case (state_r)
            RUN:     stall = hazard_s;
            BUBBLE:  stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    assign wb_valid = v_r;
    assign wb_rd    = rd_r;
    assign wb_value = val_r;
    assign retired  = retired_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized, model-checked bench for wb_regfile (default and 4-bit counter builds).
module tb_wb_regfile;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        Wr_MEM, Rm_MEM, use_a, use_b, Rm_EX;
    logic [1:0]  rdmem, rs_a, rs_b, rd_EX;
    logic [7:0]  data_out, acOutWb;
    logic [7:0]  regA, regB, wb_value, regA4, regB4, wb_value4;
    logic        stall, wb_valid, stall4, wb_valid4;
    logic [1:0]  wb_rd, wb_rd4;
    logic [15:0] retired;
    logic [3:0]  retired4;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: architectural registers, one pending write, a write
    // count, and whether the previous cycle stalled.
    logic [7:0] m_regs [4];
    logic       m_v;
    logic [1:0] m_rd;
    logic [7:0] m_val;
    int         m_cnt;
    bit         m_stalled;

    always #5 clock = ~clock;

    wb_regfile dut (
        .clock(clock), .reset_n(reset_n), .Wr_MEM(Wr_MEM), .Rm_MEM(Rm_MEM),
        .rdmem(rdmem), .data_out(data_out), .acOutWb(acOutWb), .rs_a(rs_a),
        .rs_b(rs_b), .use_a(use_a), .use_b(use_b), .Rm_EX(Rm_EX), .rd_EX(rd_EX),
        .regA(regA), .regB(regB), .stall(stall), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_value(wb_value), .retired(retired)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .Wr_MEM(Wr_MEM), .Rm_MEM(Rm_MEM),
        .rdmem(rdmem), .data_out(data_out), .acOutWb(acOutWb), .rs_a(rs_a),
        .rs_b(rs_b), .use_a(use_a), .use_b(use_b), .Rm_EX(Rm_EX), .rd_EX(rd_EX),
        .regA(regA4), .regB(regB4), .stall(stall4), .wb_valid(wb_valid4),
        .wb_rd(wb_rd4), .wb_value(wb_value4), .retired(retired4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_v = 1'b0; m_rd = 2'd0; m_val = 8'h00; m_cnt = 0; m_stalled = 1'b0;
    endtask

    function automatic bit hazard_now();
        return Rm_EX && ((use_a && rd_EX == rs_a) || (use_b && rd_EX == rs_b));
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] a);
        return (m_v && m_rd == a) ? m_val : m_regs[a];
    endfunction

    task automatic model_edge();
        bit st;
        if (!reset_n) begin
            model_reset();
        end else begin
            st = hazard_now() && !m_stalled;
            if (m_v) begin
                m_regs[m_rd] = m_val;
                m_cnt++;
            end
            m_v = Wr_MEM; m_rd = rdmem;
            m_val = Rm_MEM ? data_out : acOutWb;
            m_stalled = st;
        end
    endtask

    task automatic compare_model();
        int c16, c4;
        c16 = (m_cnt > 65535) ? 65535 : m_cnt;
        c4  = (m_cnt > 15) ? 15 : m_cnt;
        chk("m_wb_valid", {31'd0, wb_valid}, {31'd0, m_v});
        chk("m_wb_rd",    {30'd0, wb_rd},    {30'd0, m_rd});
        chk("m_wb_value", {24'd0, wb_value}, {24'd0, m_val});
        chk("m_regA",     {24'd0, regA},     {24'd0, m_read(rs_a)});
        chk("m_regB",     {24'd0, regB},     {24'd0, m_read(rs_b)});
        chk("m_stall",    {31'd0, stall},    {31'd0, hazard_now() && !m_stalled});
        chk("m_retired",  {16'd0, retired},  c16);
        chk("m_retired4", {28'd0, retired4}, c4);
        chk("m_regA4",    {24'd0, regA4},    {24'd0, m_read(rs_a)});
        chk("m_stall4",   {31'd0, stall4},   {31'd0, hazard_now() && !m_stalled});
    endtask

    // One clock: model follows the edge, then all outputs checked on the falling edge.
    task automatic cyc();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_model();
    endtask

    initial begin
        reset_n = 1'b0;
        Wr_MEM = 1'b0; Rm_MEM = 1'b0; rdmem = 2'd0; data_out = 8'h00; acOutWb = 8'h00;
        rs_a = 2'd0; rs_b = 2'd0; use_a = 1'b0; use_b = 1'b0; Rm_EX = 1'b0; rd_EX = 2'd0;
        model_reset();
        #3;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_value", {24'd0, wb_value}, 32'd0);
        chk("rst_stall",    {31'd0, stall},    32'd0);
        chk("rst_regA",     {24'd0, regA},     32'd0);
        chk("rst_regB",     {24'd0, regB},     32'd0);
        chk("rst_retired",  {16'd0, retired},  32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // ALU write to r2 with bypass, then architectural commit.
        Wr_MEM = 1'b1; rdmem = 2'd2; acOutWb = 8'h5A; rs_a = 2'd2;
        cyc();
        chk("t1_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("t1_wb_value", {24'd0, wb_value}, 32'h5A);
        chk("t1_bypass",   {24'd0, regA},     32'h5A);
        Wr_MEM = 1'b0;
        cyc();
        chk("t1_regs2",    {24'd0, regA},     32'h5A);
        chk("t1_retired",  {16'd0, retired},  32'd1);

        // Load select.
        Wr_MEM = 1'b1; Rm_MEM = 1'b1; data_out = 8'hC3; acOutWb = 8'h11; rdmem = 2'd1;
        cyc();
        chk("t2_load_sel", {24'd0, wb_value}, 32'hC3);
        Wr_MEM = 1'b0; Rm_MEM = 1'b0;

        // Load-use stall for one cycle only.
        Rm_EX = 1'b1; rd_EX = 2'd3; rs_b = 2'd3; use_b = 1'b1;
        #1 chk("t3_stall_on", {31'd0, stall}, 32'd1);
        cyc();
        chk("t3_bubble", {31'd0, stall}, 32'd0);
        cyc();
        chk("t3_run_again", {31'd0, stall}, 32'd1);
        use_b = 1'b0;
        #1 chk("t3_no_use", {31'd0, stall}, 32'd0);
        cyc();
        chk("t3_no_use2", {31'd0, stall}, 32'd0);
        Rm_EX = 1'b0;

        // Write r0 = 3C, then a write-disabled capture of FF must not land.
        Wr_MEM = 1'b1; rdmem = 2'd0; acOutWb = 8'h3C;
        cyc();
        Wr_MEM = 1'b0; acOutWb = 8'hFF; rs_a = 2'd0;
        cyc();
        chk("t4_valid0",  {31'd0, wb_valid}, 32'd0);
        chk("t4_nobypass", {24'd0, regA},    32'h3C);
        cyc();
        chk("t4_regs0",   {24'd0, regA},     32'h3C);
        chk("t4_retired", {16'd0, retired},  32'd3);

        // 20 back-to-back writes saturate the 4-bit counter.
        Wr_MEM = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rdmem = 2'($urandom_range(3)); acOutWb = 8'($urandom);
            cyc();
        end
        Wr_MEM = 1'b0;
        cyc();
        chk("t5_sat4",   {28'd0, retired4}, 32'hF);
        chk("t5_cnt16",  {16'd0, retired},  32'd23);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            Wr_MEM = 1'($urandom); Rm_MEM = 1'($urandom); rdmem = 2'($urandom);
            data_out = 8'($urandom); acOutWb = 8'($urandom);
            rs_a = 2'($urandom); rs_b = 2'($urandom);
            use_a = 1'($urandom); use_b = 1'($urandom);
            Rm_EX = ($urandom_range(3) != 0); rd_EX = 2'($urandom);
            cyc();
        end

        // Reset in BUBBLE with a write pending to r3.
        reset_n = 1'b0;
        Wr_MEM = 1'b0; Rm_EX = 1'b0; use_a = 1'b0; use_b = 1'b0;
        #1 model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        Wr_MEM = 1'b1; rdmem = 2'd3; acOutWb = 8'hA5;
        Rm_EX = 1'b1; rd_EX = 2'd1; rs_a = 2'd1; use_a = 1'b1; rs_b = 2'd3;
        cyc();
        chk("t6_pending", {31'd0, wb_valid}, 32'd1);
        chk("t6_bubble",  {31'd0, stall},    32'd0);
        #1 reset_n = 1'b0;
        Wr_MEM = 1'b0; Rm_EX = 1'b0;
        #1 model_reset();
        chk("t6_rst_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cyc();
        chk("t6_r3_zero", {24'd0, regB},  32'd0);
        chk("t6_stall0",  {31'd0, stall}, 32'd0);
        Rm_EX = 1'b1;
        #1 chk("t6_run", {31'd0, stall}, 32'd1);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
